// File: rtl/adder_axil_pkg.sv
// Register map, response codes and STATUS field layout shared by the
// adder AXI4-Lite register block and its status tracker.
package adder_axil_pkg;

  localparam logic [3:0] ADDR_A      = 4'h0;
  localparam logic [3:0] ADDR_B      = 4'h4;
  localparam logic [3:0] ADDR_SUM    = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  localparam int SUM_VALID_BIT = 0;
  localparam int OP_COUNT_LSB  = 16;
  localparam int OP_COUNT_W    = 16;

endpackage

// File: rtl/adder_axil_status.sv
// SUM_VALID tracker and OP_COUNT counter: an operand write invalidates the
// sum, which becomes valid one edge later once the registered adder catches up.
module adder_axil_status
  import adder_axil_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_wr_i,
  output logic                  sum_valid_o,
  output logic [OP_COUNT_W-1:0] op_count_o
);

  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic [OP_COUNT_W-1:0] count_q, count_d;

  always_comb begin
    pend_d  = op_wr_i;
    valid_d = valid_q;
    if (op_wr_i) begin
      valid_d = 1'b0;
    end else if (pend_q) begin
      valid_d = 1'b1;
    end
    count_d = count_q;
    if (!valid_q && valid_d) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign sum_valid_o = valid_q;
  assign op_count_o  = count_q;

endmodule

// File: rtl/adder_axil_regs.sv
// AXI4-Lite slave holding adder operands A/B and reporting the registered
// sum plus its validity/operation count through a small register map.
module adder_axil_regs
  import adder_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   op_a,
  output logic [DATA_WIDTH-1:0]   op_b,
  input  logic [DATA_WIDTH-1:0]   sum_in
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, rdata_q, rdata_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] aw_word, ar_word;
  logic                  wr_hs, rd_hs, op_wr;
  logic                  sum_valid;
  logic [OP_COUNT_W-1:0] op_count;
  logic [DATA_WIDTH-1:0] status_w, rd_mux;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Byte offset bits are masked so word aliases decode identically.
  assign aw_word = s_axi_awaddr & ~ADDR_WIDTH'(3);
  assign ar_word = s_axi_araddr & ~ADDR_WIDTH'(3);

  assign s_axi_awready = reset & s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
  assign s_axi_wready  = s_axi_awready;
  assign s_axi_arready = reset & s_axi_arvalid & ~rvalid_q;
  assign wr_hs = s_axi_awready;
  assign rd_hs = s_axi_arready;
  assign op_wr = wr_hs && (aw_word == ADDR_WIDTH'(ADDR_A) || aw_word == ADDR_WIDTH'(ADDR_B));

  always_comb begin
    status_w = '0;
    status_w[SUM_VALID_BIT] = sum_valid;
    status_w[OP_COUNT_LSB +: OP_COUNT_W] = op_count;
    case (ar_word)
      ADDR_WIDTH'(ADDR_A):      rd_mux = a_q;
      ADDR_WIDTH'(ADDR_B):      rd_mux = b_q;
      ADDR_WIDTH'(ADDR_SUM):    rd_mux = sum_in;
      ADDR_WIDTH'(ADDR_STATUS): rd_mux = status_w;
      default:                  rd_mux = '0;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (wr_hs) begin
      if (aw_word == ADDR_WIDTH'(ADDR_A)) a_d = merge_bytes(a_q, s_axi_wdata, s_axi_wstrb);
      if (aw_word == ADDR_WIDTH'(ADDR_B)) b_d = merge_bytes(b_q, s_axi_wdata, s_axi_wstrb);
      bvalid_d = 1'b1;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
    if (rd_hs) begin
      rdata_d  = rd_mux;
      rvalid_d = 1'b1;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      rdata_q  <= rdata_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
    end
  end

  adder_axil_status u_status (
    .clk         (clk),
    .reset       (reset),
    .op_wr_i     (op_wr),
    .sum_valid_o (sum_valid),
    .op_count_o  (op_count)
  );

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = RESP_OKAY;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = RESP_OKAY;
  assign op_a = a_q;
  assign op_b = b_q;

endmodule
